mem_wb_pipe_reg: RTL and testbench

//  Parametrised MEM->WB pipeline stage: successor of the fixed 32-bit MEM/WB register.

---
 rtl/mem_wb_pipe_reg.sv | 115 +++++++++++
 tb/tb_mem_wb_pipe_reg.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline stage with valid/ready flow control, flush, write-back select and retire counter.
// Optional MEM_WB_SKID_EN: two-entry skid buffer with a registered in_ready.
module mem_wb_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    input  logic                  RegWrite,
    input  logic                  MemtoReg,
    input  logic [DATA_W-1:0]     ALUresult,
    input  logic [DATA_W-1:0]     readData,
    input  logic [REG_ADDR_W-1:0] writeReg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  RegWriteOut,
    output logic                  MemtoRegOut,
    output logic [DATA_W-1:0]     ALUresultOut,
    output logic [DATA_W-1:0]     readDataOut,
    output logic [REG_ADDR_W-1:0] writeRegOut,
    output logic [DATA_W-1:0]     wbData,
    output logic [CNT_W-1:0]      retired_count
);

    localparam int ENT_W = 2 + 2 * DATA_W + REG_ADDR_W;

    logic [ENT_W-1:0]      in_ent;
    logic [ENT_W-1:0]      main_q;
    logic                  valid_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  reg_write_q;
    logic                  accept;
    logic                  consume;
    logic                  zero_dest;

    assign in_ent  = {RegWrite, MemtoReg, ALUresult, readData, writeReg};
    assign accept  = in_valid & in_ready;
    assign consume = valid_q & out_ready;

    assign {reg_write_q, MemtoRegOut, ALUresultOut, readDataOut, writeRegOut} = main_q;

    assign out_valid     = valid_q;
    assign retired_count = cnt_q;
    assign zero_dest     = (ZERO_REG != 0) && (writeRegOut == '0);
    assign RegWriteOut   = reg_write_q & valid_q & ~zero_dest;
    assign wbData        = MemtoRegOut ? readDataOut : ALUresultOut;

    // Retire counter counts every handshake, flush does not clear it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (consume) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

`ifdef MEM_WB_SKID_EN
    logic [ENT_W-1:0] skid_q;
    logic             skid_full_q;

    // in_ready depends only on a flop, so out_ready never reaches it combinationally.
    assign in_ready = ~skid_full_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
            skid_full_q <= 1'b0;
        end else if (flush) begin
            valid_q     <= 1'b0;
            skid_full_q <= 1'b0;
        end else if (consume) begin
            if (skid_full_q) begin
                main_q      <= skid_q;
                skid_full_q <= 1'b0;
            end else if (accept) begin
                main_q <= in_ent;
            end else begin
                valid_q <= 1'b0;
            end
        end else if (accept) begin
            if (valid_q) begin
                skid_q      <= in_ent;
                skid_full_q <= 1'b1;
            end else begin
                main_q  <= in_ent;
                valid_q <= 1'b1;
            end
        end
    end
`else
    assign in_ready = ~valid_q | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            main_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            main_q  <= in_ent;
            valid_q <= 1'b1;
        end else if (consume) begin
            valid_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Directed bench for mem_wb_pipe_reg: reset, latency, hold, x0 suppression, flush, counter wrap.
module tb_mem_wb_pipe_reg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 4;
`ifdef MEM_WB_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic                  clk;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic                  flush;
    logic                  RegWrite;
    logic                  MemtoReg;
    logic [DATA_W-1:0]     ALUresult;
    logic [DATA_W-1:0]     readData;
    logic [REG_ADDR_W-1:0] writeReg;
    logic                  out_valid;
    logic                  out_ready;
    logic                  RegWriteOut;
    logic                  MemtoRegOut;
    logic [DATA_W-1:0]     ALUresultOut;
    logic [DATA_W-1:0]     readDataOut;
    logic [REG_ADDR_W-1:0] writeRegOut;
    logic [DATA_W-1:0]     wbData;
    logic [CNT_W-1:0]      retired_count;

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [CNT_W-1:0] exp_cnt;

    mem_wb_pipe_reg #(
        .DATA_W    (DATA_W),
        .REG_ADDR_W(REG_ADDR_W),
        .CNT_W     (CNT_W),
        .ZERO_REG  (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .flush        (flush),
        .RegWrite     (RegWrite),
        .MemtoReg     (MemtoReg),
        .ALUresult    (ALUresult),
        .readData     (readData),
        .writeReg     (writeReg),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .RegWriteOut  (RegWriteOut),
        .MemtoRegOut  (MemtoRegOut),
        .ALUresultOut (ALUresultOut),
        .readDataOut  (readDataOut),
        .writeRegOut  (writeRegOut),
        .wbData       (wbData),
        .retired_count(retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        RegWrite = 1'b0; MemtoReg = 1'b0; ALUresult = '0; readData = '0; writeReg = '0;
        exp_cnt = '0;

        // reset
        step(); step();
        check("rst_out_valid", out_valid, 0);
        check("rst_regwrite", RegWriteOut, 0);
        check("rst_wbdata", wbData, 0);
        check("rst_count", retired_count, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        // single transfer, ALU path
        in_valid = 1'b1; RegWrite = 1'b1; MemtoReg = 1'b0; ALUresult = 32'h1234;
        readData = 32'h5555; writeReg = 5'd5; out_ready = 1'b1;
        step();
        check("t2_out_valid", out_valid, 1);
        check("t2_regwrite", RegWriteOut, 1);
        check("t2_wbdata", wbData, 32'h1234);
        check("t2_writereg", writeRegOut, 5);
        check("t2_count0", retired_count, 0);
        in_valid = 1'b0;
        step();
        exp_cnt++;
        check("t2_count1", retired_count, exp_cnt);
        check("t2_drained", out_valid, 0);

        // hold under back-pressure, memory path
        in_valid = 1'b1; MemtoReg = 1'b1; readData = 32'hDEADBEEF; ALUresult = 32'h1111;
        writeReg = 5'd7; out_ready = 1'b0;
        step();
        check("t3_out_valid", out_valid, 1);
        check("t3_wbdata", wbData, 32'hDEADBEEF);
        check("t3_regwrite", RegWriteOut, 1);
        MemtoReg = 1'b0; ALUresult = 32'h2222; readData = 32'h3333; writeReg = 5'd8;
        #1;
        check("t3_in_ready_held", in_ready, SKID ? 1 : 0);
        step();
        check("t3_hold2_wbdata", wbData, 32'hDEADBEEF);
        check("t3_hold2_writereg", writeRegOut, 7);
        check("t3_in_ready_full", in_ready, 0);
        in_valid = 1'b0;
        step();
        check("t3_hold3_wbdata", wbData, 32'hDEADBEEF);
        check("t3_hold3_valid", out_valid, 1);
        check("t3_hold3_count", retired_count, exp_cnt);
        out_ready = 1'b1;
        #1;
        check("t3_in_ready_release", in_ready, SKID ? 0 : 1);
        step();
        exp_cnt++;
        check("t3_consume_count", retired_count, exp_cnt);
        check("t3_consume_valid", out_valid, SKID ? 1 : 0);
        step();
        exp_cnt = exp_cnt + (SKID ? 4'd1 : 4'd0);
        check("t3_drain_count", retired_count, exp_cnt);
        check("t3_drain_valid", out_valid, 0);

        // x0 write suppression
        in_valid = 1'b1; RegWrite = 1'b1; MemtoReg = 1'b0; writeReg = 5'd0;
        ALUresult = 32'h77; out_ready = 1'b0;
        step();
        check("t4_out_valid", out_valid, 1);
        check("t4_regwrite_x0", RegWriteOut, 0);
        check("t4_wbdata", wbData, 32'h77);

        // flush with held entry and incoming valid
        flush = 1'b1; in_valid = 1'b1; writeReg = 5'd9; ALUresult = 32'h99;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("t5_flush_valid", out_valid, 0);
        check("t5_flush_count", retired_count, exp_cnt);
        check("t5_flush_in_ready", in_ready, 1);
        step();
        check("t5_dropped_input", out_valid, 0);

        // flush coinciding with consume still counts
        in_valid = 1'b1; ALUresult = 32'h55; writeReg = 5'd4; out_ready = 1'b0;
        step();
        check("t5b_loaded", out_valid, 1);
        in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
        step();
        exp_cnt++;
        flush = 1'b0;
        check("t5b_valid", out_valid, 0);
        check("t5b_count", retired_count, exp_cnt);

        // stream until counter reaches 15, then wrap
        in_valid = 1'b1; out_ready = 1'b1; ALUresult = 32'h100; writeReg = 5'd1;
        step();
        check("t6_first", wbData, 32'h100);
        for (int j = 1; j < 40 && exp_cnt != 4'd15; j++) begin
            ALUresult = 32'h100 + 32'(j);
            step();
            exp_cnt++;
            check("t6_stream_data", wbData, 32'h100 + 32'(j));
        end
        check("t6_count15", retired_count, 15);
        in_valid = 1'b0;
        step();
        exp_cnt++;
        check("t6_wrap", retired_count, 0);
        check("t6_wrap_valid", out_valid, 0);

        // reset while an entry is held
        in_valid = 1'b1; ALUresult = 32'hABC; writeReg = 5'd3; RegWrite = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        exp_cnt++;
        in_valid = 1'b1; ALUresult = 32'hDEF; out_ready = 1'b0;
        step();
        check("t7_held_valid", out_valid, 1);
        check("t7_count", retired_count, exp_cnt);
        rst = 1'b1; in_valid = 1'b0;
        step();
        rst = 1'b0;
        check("t7_rst_valid", out_valid, 0);
        check("t7_rst_regwrite", RegWriteOut, 0);
        check("t7_rst_wbdata", wbData, 0);
        check("t7_rst_alu", ALUresultOut, 0);
        check("t7_rst_writereg", writeRegOut, 0);
        check("t7_rst_count", retired_count, 0);
        check("t7_rst_in_ready", in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
